// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: BYTES_PER_CYCLE state bytes substituted per cycle.
// Define SUB_BYTES_INVERSE_EN to build the inverse S-box and honour `inverse`.
package sub_bytes_pkg;
    typedef logic [0:15][7:0] state_t;
endpackage

module sub_bytes_iter
    import sub_bytes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic   clock,
    input  logic   reset,
    input  state_t in,
    input  logic   in_valid,
    output logic   in_ready,
    input  logic   inverse,
    output state_t out,
    output logic   out_valid,
    input  logic   out_ready
);

    localparam int GROUPS = 16 / BYTES_PER_CYCLE;
    localparam int CW = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e        st;
    state_e        st_nx;
    logic [CW-1:0] cnt;
    state_t        work;
    state_t        sub;
    logic          last;

    function automatic logic [7:0] gmul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8); 0 maps to 0
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                 ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

`ifdef SUB_BYTES_INVERSE_EN
    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]}
          ^ {a[1:0], a[7:2]} ^ 8'h05;
        return ginv(b);
    endfunction

    logic inv_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            inv_q <= 1'b0;
        end else if (st == IDLE && in_valid) begin
            inv_q <= inverse;
        end
    end
`else
    logic unused_inverse;
    assign unused_inverse = inverse;
`endif

    assign last      = (cnt == CW'(GROUPS - 1));
    assign in_ready  = (st == IDLE);
    assign out_valid = (st == DONE);
    assign out       = work;

    // Substitute the current group in place; other bytes pass through
    always_comb begin
        logic [3:0] idx;
        idx = '0;
        sub = work;
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
            idx = 4'(int'(cnt) * BYTES_PER_CYCLE + j);
`ifdef SUB_BYTES_INVERSE_EN
            sub[idx] = inv_q ? inv_sbox(work[idx])
                             : fwd_sbox(work[idx]);
`else
            sub[idx] = fwd_sbox(work[idx]);
`endif
        end
    end

    always_comb begin
        st_nx = st;
        case (st)
            IDLE:    if (in_valid) st_nx = BUSY;
            BUSY:    if (last) st_nx = DONE;
            DONE:    if (out_ready) st_nx = IDLE;
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            st   <= IDLE;
            cnt  <= '0;
            work <= '0;
        end else begin
            st <= st_nx;
            if (st == IDLE && in_valid) begin
                work <= in;
                cnt  <= '0;
            end else if (st == BUSY) begin
                work <= sub;
                cnt  <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Scoreboard bench for sub_bytes_iter at BYTES_PER_CYCLE 4, 1 and 16.
// Expected states come from an S-box table built by the GF(2^8) generator walk.
module tb_sub_bytes_iter;
    import sub_bytes_pkg::*;

`ifdef SUB_BYTES_INVERSE_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic   rst[3];
    state_t din[3];
    state_t dout[3];
    logic   iv[3];
    logic   ir[3];
    logic   inv[3];
    logic   ov[3];
    logic   ordy[3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sub_bytes_iter #(
            .BYTES_PER_CYCLE(g == 0 ? 4 : (g == 1 ? 1 : 16))
        ) u_dut (
            .clock    (clk),
            .reset    (rst[g]),
            .in       (din[g]),
            .in_valid (iv[g]),
            .in_ready (ir[g]),
            .inverse  (inv[g]),
            .out      (dout[g]),
            .out_valid(ov[g]),
            .out_ready(ordy[g])
        );
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ncmp = 0;
    int nerr = 0;

    bit [7:0] sb[256];
    bit [7:0] isb[256];

    state_t exp_q[3][$];
    int     acc_q[3][$];
    state_t held[3];
    bit     seen[3];

    function automatic int lat_of(input int k);
        return k == 0 ? 4 : (k == 1 ? 16 : 1);
    endfunction

    function automatic bit [7:0] rl(input bit [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_tables();
        bit [7:0] p;
        bit [7:0] q;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            sb[p] = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4) ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    endtask

    function automatic state_t exp_of(input state_t s, input bit use_inv);
        state_t r;
        for (int i = 0; i < 16; i++)
            r[i] = (use_inv && INV_EN) ? isb[s[i]] : sb[s[i]];
        return r;
    endfunction

    function automatic state_t rand_state();
        state_t r;
        for (int i = 0; i < 16; i++) r[i] = 8'($urandom);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] want);
        ncmp++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", nm, act, want);
        end
    endtask

    task automatic timeout(input string nm);
        ncmp++;
        nerr++;
        $display("FAIL %s: got timeout, want event", nm);
    endtask

    // Present s until accepted, then scramble the inputs
    task automatic issue(input int k, input state_t s, input bit iv_,
                         input state_t want);
        int t;
        @(posedge clk); #1;
        din[k] = s;
        inv[k] = iv_;
        iv[k]  = 1'b1;
        t = 0;
        @(negedge clk);
        while (ir[k] !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (ir[k] !== 1'b1) begin
            timeout($sformatf("accept%0d", k));
            iv[k] = 1'b0;
            return;
        end
        exp_q[k].push_back(want);
        acc_q[k].push_back(cyc + 1);
        @(posedge clk); #1;
        iv[k]  = 1'b0;
        din[k] = rand_state();
        inv[k] = ~iv_;
        @(negedge clk);
        chk($sformatf("busy_in_ready%0d", k), 128'(ir[k]), 128'(0));
    endtask

    task automatic drain(input int k);
        int t;
        t = 0;
        while (exp_q[k].size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (exp_q[k].size() != 0) timeout($sformatf("drain%0d", k));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (rst[k] !== 1'b0) begin
                    seen[k] = 1'b0;
                end else if (ov[k] === 1'b1) begin
                    if (exp_q[k].size() == 0) begin
                        timeout($sformatf("unexpected_valid%0d", k));
                    end else if (!seen[k]) begin
                        chk($sformatf("latency%0d", k),
                            128'(cyc - acc_q[k][0]), 128'(lat_of(k)));
                        chk($sformatf("data%0d", k), dout[k], exp_q[k][0]);
                        held[k] = dout[k];
                        seen[k] = 1'b1;
                    end else begin
                        chk($sformatf("stable%0d", k), dout[k], held[k]);
                        chk($sformatf("done_in_ready%0d", k),
                            128'(ir[k]), 128'(0));
                    end
                    if (ordy[k] === 1'b1 && exp_q[k].size() != 0) begin
                        void'(exp_q[k].pop_front());
                        void'(acc_q[k].pop_front());
                        seen[k] = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        state_t s;
        bit     b;
        int     k;
        build_tables();
        for (int i = 0; i < 3; i++) begin
            rst[i]  = 1'b1;
            iv[i]   = 1'b0;
            inv[i]  = 1'b0;
            ordy[i] = 1'b1;
            din[i]  = '0;
            seen[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_in_ready%0d", i), 128'(ir[i]), 128'(1));
            chk($sformatf("rst_valid%0d", i), 128'(ov[i]), 128'(0));
            chk($sformatf("rst_out%0d", i), dout[i], 128'h0);
        end

        issue(0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0,
              128'hd42711aee0bf98f1b8b45de51e415230);
        drain(0);
        s = 128'hd42711aee0bf98f1b8b45de51e415230;
        issue(0, s, 1'b1, INV_EN ?
              state_t'(128'h193de3bea0f4e22b9ac68d2ae9f84808) :
              exp_of(s, 1'b0));
        drain(0);

        issue(1, '0, 1'b0, {16{8'h63}});
        issue(2, '0, 1'b0, {16{8'h63}});
        drain(1);
        drain(2);

        // back-pressure: hold the result in DONE for 10 cycles
        ordy[0] = 1'b0;
        s = rand_state();
        issue(0, s, 1'b0, exp_of(s, 1'b0));
        for (int t = 0; t < 30 && ov[0] !== 1'b1; t++) @(negedge clk);
        if (ov[0] !== 1'b1) timeout("bp_valid");
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            chk("bp_hold_valid", 128'(ov[0]), 128'(1));
        end
        @(posedge clk); #1;
        ordy[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_valid", 128'(ov[0]), 128'(0));
        chk("bp_release_ready", 128'(ir[0]), 128'(1));

        // reset on the second BUSY cycle aborts without output
        s = rand_state();
        issue(0, s, 1'b1, exp_of(s, 1'b1));
        @(posedge clk); #1;
        rst[0] = 1'b1;
        exp_q[0].delete();
        acc_q[0].delete();
        @(posedge clk); #1;
        rst[0] = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", 128'(ir[0]), 128'(1));
        chk("abort_valid", 128'(ov[0]), 128'(0));
        repeat (8) @(negedge clk);
        s = rand_state();
        issue(0, s, 1'b0, exp_of(s, 1'b0));
        drain(0);

        for (int n = 0; n < 60; n++) begin
            k = int'($urandom_range(0, 2));
            b = 1'($urandom);
            s = rand_state();
            issue(k, s, b, exp_of(s, b));
        end
        for (int i = 0; i < 3; i++) drain(i);

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end

endmodule
